pbkdf2_prf_arbiter: RTL and testbench

PBKDF2_PRF_ARBITER -- requirements
Module: pbkdf2_prf_arbiter

---
 rtl/pbkdf2_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/pbkdf2_prf_arbiter.sv | 130 +++++++++++++
 tb/tb_pbkdf2_prf_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared definitions for the PBKDF2 PRF arbiter slice.
// Holds the arbiter FSM encoding and default datapath width.
package pbkdf2_pkg;

   localparam int W_DEFAULT = 256;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETURN
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// Returns one-hot grant, binary index and an any-request flag.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   logic [PW:0]   w_sum;
   logic [PW-1:0] w_pos;
   logic          w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
         w_pos = w_sum[PW-1:0];
         if (!w_found && i_req[w_pos]) begin
            o_gnt[w_pos] = 1'b1;
            o_idx        = w_pos;
            w_found      = 1'b1;
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/pbkdf2_prf_arbiter.sv
// Shares one HMAC-SHA256 PRF core among NUM_REQ requesters,
// one transaction in flight, round-robin fairness.
module pbkdf2_prf_arbiter
   import pbkdf2_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int W       = W_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_v_i,
   input  logic [NUM_REQ*W-1:0] req_key_i,
   input  logic [NUM_REQ*W-1:0] req_msg_i,
   output logic [NUM_REQ-1:0]   req_r_o,
   output logic [NUM_REQ-1:0]   resp_v_o,
   output logic [W-1:0]         resp_data_o,
   input  logic [NUM_REQ-1:0]   resp_r_i,
   output logic                 prf_v_o,
   input  logic                 prf_r_i,
   output logic [W-1:0]         prf_key_o,
   output logic [W-1:0]         prf_msg_o,
   input  logic                 prf_res_v_i,
   input  logic [W-1:0]         prf_res_i,
   output logic                 prf_res_r_o
);

   localparam int PW = $clog2(NUM_REQ);

   state_e              r_state;
   state_e              w_next;
   logic [PW-1:0]       r_ptr;
   logic [PW-1:0]       r_owner;
   logic [W-1:0]        r_key;
   logic [W-1:0]        r_msg;
   logic [W-1:0]        r_data;
   logic [15:0]         r_cnt [NUM_REQ];
   logic [NUM_REQ-1:0]  w_gnt;
   logic [PW-1:0]       w_idx;
   logic                w_any;
   logic                w_take;
   logic                w_done;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req (req_v_i),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Grant is masked during reset so no request is accepted while held.
   always_comb begin
      w_next      = r_state;
      req_r_o     = '0;
      prf_v_o     = 1'b0;
      prf_res_r_o = 1'b0;
      resp_v_o    = '0;
      w_take      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any && !rst_i) begin
               req_r_o = w_gnt;
               w_take  = 1'b1;
               w_next  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            prf_v_o = 1'b1;
            if (prf_r_i) w_next = S_WAIT;
         end
         S_WAIT: begin
            prf_res_r_o = 1'b1;
            if (prf_res_v_i) w_next = S_RETURN;
         end
         S_RETURN: begin
            resp_v_o[r_owner] = 1'b1;
            if (resp_r_i[r_owner]) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_key   <= '0;
         r_msg   <= '0;
         r_data  <= '0;
      end else begin
         if (w_take) begin
            r_owner <= w_idx;
            r_key   <= req_key_i[int'(w_idx)*W +: W];
            r_msg   <= req_msg_i[int'(w_idx)*W +: W];
         end
         if (prf_res_r_o && prf_res_v_i) r_data <= prf_res_i;
         if (w_done) begin
            r_ptr <= (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
      end else if (w_done) begin
         r_cnt[r_owner] <= r_cnt[r_owner] + 16'd1;
      end
   end

   assign prf_key_o   = r_key;
   assign prf_msg_o   = r_msg;
   assign resp_data_o = r_data;

   a_excl: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0({prf_v_o, prf_res_r_o, |resp_v_o}));

   a_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
      w_done |=> r_cnt[$past(r_owner)] == $past(r_cnt[r_owner]) + 16'd1);

endmodule

// File: tb/tb_pbkdf2_prf_arbiter.sv
// Randomized and directed bench for pbkdf2_prf_arbiter against
// a circular-search round-robin reference model.
module tb_pbkdf2_prf_arbiter;

   localparam int N = 4;
   localparam int W = 256;

   logic           clk = 1'b0;
   logic           rst_i;
   logic [N-1:0]   req_v_i;
   logic [N*W-1:0] req_key_i;
   logic [N*W-1:0] req_msg_i;
   logic [N-1:0]   req_r_o;
   logic [N-1:0]   resp_v_o;
   logic [W-1:0]   resp_data_o;
   logic [N-1:0]   resp_r_i;
   logic           prf_v_o;
   logic           prf_r_i;
   logic [W-1:0]   prf_key_o;
   logic [W-1:0]   prf_msg_o;
   logic           prf_res_v_i;
   logic [W-1:0]   prf_res_i;
   logic           prf_res_r_o;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;

   pbkdf2_prf_arbiter #(.NUM_REQ(N), .W(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_v_i     (req_v_i),
      .req_key_i   (req_key_i),
      .req_msg_i   (req_msg_i),
      .req_r_o     (req_r_o),
      .resp_v_o    (resp_v_o),
      .resp_data_o (resp_data_o),
      .resp_r_i    (resp_r_i),
      .prf_v_o     (prf_v_o),
      .prf_r_i     (prf_r_i),
      .prf_key_o   (prf_key_o),
      .prf_msg_o   (prf_msg_o),
      .prf_res_v_i (prf_res_v_i),
      .prf_res_i   (prf_res_i),
      .prf_res_r_o (prf_res_r_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // First requester met walking the circle from the pointer.
   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int i = 0; i < N; i++)
         if (m[(p+i)%N]) return (p+i)%N;
      return -1;
   endfunction

   task automatic scramble();
      for (int i = 0; i < N; i++) begin
         req_key_i[i*W +: W] = rand_w();
         req_msg_i[i*W +: W] = rand_w();
      end
   endtask

   // Called at a negedge with the DUT idle; returns observed winner.
   task automatic txn(input logic [N-1:0] mask, input bit rnd,
                      input logic [W-1:0] key_all,
                      input logic [W-1:0] msg_all,
                      input logic [W-1:0] res,
                      input int pw, input int rw, input int dw,
                      output int won);
      logic [N-1:0] oh;
      logic [W-1:0] ek, em;
      int w;
      if (rnd) scramble();
      else begin
         for (int i = 0; i < N; i++) begin
            req_key_i[i*W +: W] = key_all;
            req_msg_i[i*W +: W] = msg_all;
         end
      end
      req_v_i = mask;
      #1;
      won = -1;
      for (int i = N-1; i >= 0; i--) if (req_r_o[i]) won = i;
      w  = pick(mask, m_ptr);
      oh = '0;
      if (w >= 0) oh[w] = 1'b1;
      check("grant", req_r_o, oh);
      check("idle_prf_v", prf_v_o, 0);
      if (w < 0) begin
         @(negedge clk);
         req_v_i = '0;
         return;
      end
      ek = req_key_i[w*W +: W];
      em = req_msg_i[w*W +: W];
      @(negedge clk);
      req_v_i = N'($urandom);
      scramble();
      prf_r_i = 1'b0;
      for (int c = 0; c < pw; c++) begin
         #1;
         check("hold_prf_v", prf_v_o, 1);
         check("hold_key", prf_key_o, ek);
         check("hold_msg", prf_msg_o, em);
         check("no_regrant", req_r_o, 0);
         @(negedge clk);
      end
      prf_r_i = 1'b1;
      #1;
      check("issue_prf_v", prf_v_o, 1);
      check("issue_key", prf_key_o, ek);
      check("issue_msg", prf_msg_o, em);
      @(negedge clk);
      prf_r_i = 1'b0;
      for (int c = 0; c < rw; c++) begin
         #1;
         check("wait_res_r", prf_res_r_o, 1);
         check("wait_prf_v", prf_v_o, 0);
         check("wait_resp_v", resp_v_o, 0);
         @(negedge clk);
      end
      prf_res_v_i = 1'b1;
      prf_res_i   = res;
      #1;
      check("take_res_r", prf_res_r_o, 1);
      @(negedge clk);
      prf_res_v_i = 1'b0;
      prf_res_i   = rand_w();
      resp_r_i    = ~oh;
      for (int c = 0; c < dw; c++) begin
         #1;
         check("ret_hold_v", resp_v_o, oh);
         check("ret_hold_d", resp_data_o, res);
         check("ret_no_grant", req_r_o, 0);
         check("ret_res_r", prf_res_r_o, 0);
         @(negedge clk);
      end
      resp_r_i = oh | N'($urandom);
      #1;
      check("ret_v", resp_v_o, oh);
      check("ret_data", resp_data_o, res);
      check("ret_prf_v", prf_v_o, 0);
      @(negedge clk);
      resp_r_i = '0;
      req_v_i  = '0;
      m_ptr    = (w + 1) % N;
      #1;
      check("done_resp_v", resp_v_o, 0);
      check("done_prf_v", prf_v_o, 0);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_req_r"}, req_r_o, 0);
      check({tag, "_resp_v"}, resp_v_o, 0);
      check({tag, "_prf_v"}, prf_v_o, 0);
      check({tag, "_res_r"}, prf_res_r_o, 0);
      check({tag, "_data"}, resp_data_o, 0);
      check({tag, "_key"}, prf_key_o, 0);
      check({tag, "_msg"}, prf_msg_o, 0);
   endtask

   initial begin
      int won;
      int order [5];
      logic [N-1:0] mk;
      order = '{0, 1, 2, 3, 0};
      rst_i       = 1'b1;
      req_v_i     = 4'hF;
      req_key_i   = '0;
      req_msg_i   = '0;
      resp_r_i    = '0;
      prf_r_i     = 1'b0;
      prf_res_v_i = 1'b0;
      prf_res_i   = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      req_v_i = '0;
      rst_i   = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         txn(4'b1000, 1, '0, '0, rand_w(), 0, 0, 0, won);
         check("only3", won, 3);
      end

      for (int k = 0; k < 5; k++) begin
         txn(4'hF, 1, '0, '0, rand_w(), 0, 1, 0, won);
         check("rr_order", won, order[k]);
      end

      txn(4'b0100, 0, '1, '0, {32{8'hA5}}, 0, 0, 0, won);
      check("single2", won, 2);

      txn(4'b1011, 1, '0, '0, rand_w(), 5, 0, 0, won);
      txn(4'b0110, 1, '0, '0, rand_w(), 0, 0, 3, won);

      // reset while waiting on the core, then a late result
      @(negedge clk);
      req_v_i = 4'b0010;
      @(negedge clk);
      req_v_i = '0;
      prf_r_i = 1'b1;
      @(negedge clk);
      prf_r_i = 1'b0;
      #1;
      check("pre_rst_wait", prf_res_r_o, 1);
      rst_i = 1'b1;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      rst_i       = 1'b0;
      prf_res_v_i = 1'b1;
      prf_res_i   = rand_w();
      #1;
      check("late_res_r", prf_res_r_o, 0);
      @(negedge clk);
      check("late_resp_v", resp_v_o, 0);
      check("late_data", resp_data_o, 0);
      prf_res_v_i = 1'b0;
      m_ptr = 0;
      txn(4'hF, 1, '0, '0, rand_w(), 0, 0, 0, won);
      check("ptr_after_rst", won, 0);

      for (int k = 0; k < 60; k++) begin
         mk = N'($urandom_range(0, 15));
         txn(mk, 1, '0, '0, rand_w(), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), won);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
